// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Bytes per instruction word; the PC advances by this amount per fetch.
    localparam int INSTR_BYTES = 4;

    // Fetch control state: fetching, or halted on a misaligned redirect.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // One buffered fetch result handed to decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A redirect target is usable only if it is word aligned.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Memory, redirect and decode-side signals of the fetch stage.
//                master = fetch unit, slave = surrounding pipeline/memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output fault,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  fault,
        input  fetch_count
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO of fetch entries. Flush wins over
//                push; push and pop may both occur while full.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         push,
    input  wire fetch_entry_t push_data,
    input  wire logic         pop,
    input  wire logic         flush,
    output logic              full,
    output logic              empty,
    output fetch_entry_t      head
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t        r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    // A push into a full FIFO only lands if the head leaves in the same cycle;
    // when full the write slot is the head slot being vacated.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    // Storage, pointers and occupancy; flush discards contents without
    // touching the entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, drives the
//                combinational instruction memory, buffers results for
//                decode, handles redirects and a sticky misalignment fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_unit_if.master  bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  r_fetch_count;

    logic         w_enq;
    logic         w_deq;
    logic         w_flush;
    logic         w_full;
    logic         w_empty;
    logic         w_out_valid;
    fetch_entry_t w_push_data;
    fetch_entry_t w_head;

    // Head is only offered while running; in FAULT the buffer is empty anyway.
    assign w_out_valid = (r_state == RUN) & ~w_empty;
    assign w_deq       = w_out_valid & bus.out_ready;

    assign w_push_data.pc    = r_pc;
    assign w_push_data.instr = bus.imem_rdata;

    // Next state, PC and buffer controls; a redirect suppresses this cycle's
    // enqueue and a misaligned target halts fetch with the PC left as is.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_enq        = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.redirect_valid) begin
                    w_flush = 1'b1;
                    if (is_aligned(bus.redirect_pc)) begin
                        w_pc_next = bus.redirect_pc;
                    end else begin
                        w_state_next = FAULT;
                    end
                end else if (~w_full | w_deq) begin
                    w_enq     = 1'b1;
                    w_pc_next = r_pc + 32'(INSTR_BYTES);
                end
            end
            FAULT: begin
                w_state_next = FAULT;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // State and program counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Count of entries accepted by decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (w_deq) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_enq),
        .push_data (w_push_data),
        .pop       (w_deq),
        .flush     (w_flush),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign bus.imem_addr   = r_pc;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_pc      = w_head.pc;
    assign bus.out_instr   = w_head.instr;
    assign bus.fault       = (r_state == FAULT);
    assign bus.fetch_count = r_fetch_count;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed, table-driven bench for fetch_unit. Memory returns
//                addr ^ 32'hA5A5_0000. A second instance starts near the top
//                of the address space to exercise PC wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic reset;

    fetch_unit_if bus0 ();
    fetch_unit_if bus1 ();

    logic        r_ready;
    logic        r_rv;
    logic [31:0] r_rpc;
    logic        r_xdat;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        xdat;
        logic        chk_head;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_addr;
        logic        exp_fault;
        logic [31:0] exp_cnt;
    } vec_t;

    localparam int c_NVEC = 23;
    vec_t vecs [c_NVEC];

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .DEPTH    (2)
    ) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    // Combinational instruction memory models; X injected on demand.
    assign bus0.imem_rdata     = r_xdat ? 32'hxxxx_xxxx : (bus0.imem_addr ^ 32'hA5A5_0000);
    assign bus0.out_ready      = r_ready;
    assign bus0.redirect_valid = r_rv;
    assign bus0.redirect_pc    = r_rpc;

    assign bus1.imem_rdata     = bus1.imem_addr ^ 32'hA5A5_0000;
    assign bus1.out_ready      = 1'b1;
    assign bus1.redirect_valid = 1'b0;
    assign bus1.redirect_pc    = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rst, rdy, rv, input logic [31:0] rpc,
                                input logic xdat, chk, ev, input logic [31:0] epc,
                                input logic [31:0] ein, eaddr, input logic ef,
                                input logic [31:0] ecnt);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.xdat = xdat;
        v.chk_head = chk; v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ein;
        v.exp_addr = eaddr; v.exp_fault = ef; v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vectors(input int first, input int last);
        for (int i = first; i < last; i++) begin
            reset   = vecs[i].rst;
            r_ready = vecs[i].rdy;
            r_rv    = vecs[i].rv;
            r_rpc   = vecs[i].rpc;
            r_xdat  = vecs[i].xdat;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(bus0.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d imem_addr", i), bus0.imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d fault", i), 32'(bus0.fault), 32'(vecs[i].exp_fault));
            chk($sformatf("v%0d fetch_count", i), bus0.fetch_count, vecs[i].exp_cnt);
            if (vecs[i].chk_head) begin
                chk($sformatf("v%0d out_pc", i), bus0.out_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d out_instr", i), bus0.out_instr, vecs[i].exp_instr);
            end
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        r_ready = 1'b0;
        r_rv    = 1'b0;
        r_rpc   = 32'h0;
        r_xdat  = 1'b0;

        //                rst rdy rv  rpc       x  chk ev  pc          instr         addr          f  cnt
        // reset, then backpressure from release: fill to 2, PC stalls at 8
        vecs[0]  = mk(1, 0, 0, 32'h0,  0, 1, 0, 32'h0,  32'h0,         32'h0,  0, 32'd0);
        vecs[1]  = mk(0, 0, 0, 32'h0,  0, 1, 1, 32'h0,  32'hA5A5_0000, 32'h4,  0, 32'd0);
        vecs[2]  = mk(0, 0, 0, 32'h0,  0, 1, 1, 32'h0,  32'hA5A5_0000, 32'h8,  0, 32'd0);
        vecs[3]  = mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h0,  32'hA5A5_0000, 32'h8,  0, 32'd0);
        vecs[4]  = mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h0,  32'hA5A5_0000, 32'h8,  0, 32'd0);
        vecs[5]  = mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h0,  32'hA5A5_0000, 32'h8,  0, 32'd0);
        // release: full buffer with deq still enqueues, no gaps or duplicates
        vecs[6]  = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'h4,  32'hA5A5_0004, 32'hC,  0, 32'd1);
        vecs[7]  = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'h8,  32'hA5A5_0008, 32'h10, 0, 32'd2);
        vecs[8]  = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'hC,  32'hA5A5_000C, 32'h14, 0, 32'd3);
        // reset while full with out_ready low
        vecs[9]  = mk(1, 0, 0, 32'h0,  0, 1, 0, 32'h0,  32'h0,         32'h0,  0, 32'd0);
        // build buffer {4,8}, then aligned redirect with simultaneous deq
        vecs[10] = mk(0, 0, 0, 32'h0,  0, 1, 1, 32'h0,  32'hA5A5_0000, 32'h4,  0, 32'd0);
        vecs[11] = mk(0, 0, 0, 32'h0,  0, 1, 1, 32'h0,  32'hA5A5_0000, 32'h8,  0, 32'd0);
        vecs[12] = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'h4,  32'hA5A5_0004, 32'hC,  0, 32'd1);
        vecs[13] = mk(0, 1, 1, 32'h40, 0, 0, 0, 32'h0,  32'h0,         32'h40, 0, 32'd2);
        vecs[14] = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'h40, 32'hA5A5_0040, 32'h44, 0, 32'd2);
        vecs[15] = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'h44, 32'hA5A5_0044, 32'h48, 0, 32'd3);
        // misaligned redirect: deq of 44 still counts, PC held, fault sticky
        vecs[16] = mk(0, 1, 1, 32'h42, 0, 0, 0, 32'h0,  32'h0,         32'h48, 1, 32'd4);
        vecs[17] = mk(0, 1, 1, 32'h80, 1, 0, 0, 32'h0,  32'h0,         32'h48, 1, 32'd4);
        // reset clears fault; stream with out_ready held high
        vecs[18] = mk(1, 1, 0, 32'h0,  0, 1, 0, 32'h0,  32'h0,         32'h0,  0, 32'd0);
        vecs[19] = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'h0,  32'hA5A5_0000, 32'h4,  0, 32'd0);
        vecs[20] = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'h4,  32'hA5A5_0004, 32'h8,  0, 32'd1);
        vecs[21] = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'h8,  32'hA5A5_0008, 32'hC,  0, 32'd2);
        vecs[22] = mk(0, 1, 0, 32'h0,  0, 1, 1, 32'hC,  32'hA5A5_000C, 32'h10, 0, 32'd3);

        run_vectors(0, 18);

        // Fault held for 10 cycles while further redirects arrive
        for (int k = 0; k < 10; k++) begin
            reset   = 1'b0;
            r_ready = k[0];
            r_rv    = 1'b1;
            r_rpc   = k[0] ? 32'h0000_0100 : 32'h0000_0043;
            r_xdat  = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d fault", k), 32'(bus0.fault), 32'd1);
            chk($sformatf("hold%0d out_valid", k), 32'(bus0.out_valid), 32'd0);
            chk($sformatf("hold%0d imem_addr", k), bus0.imem_addr, 32'h48);
            chk($sformatf("hold%0d fetch_count", k), bus0.fetch_count, 32'd4);
        end
        r_xdat = 1'b0;
        r_rv   = 1'b0;

        run_vectors(18, c_NVEC);

        // PC wrap on the second instance: F8, FC, 0
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap reset imem_addr", bus1.imem_addr, 32'hFFFF_FFF8);
        chk("wrap reset out_valid", 32'(bus1.out_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap0 out_valid", 32'(bus1.out_valid), 32'd1);
        chk("wrap0 out_pc", bus1.out_pc, 32'hFFFF_FFF8);
        chk("wrap0 out_instr", bus1.out_instr, 32'h5A5A_FFF8);
        @(posedge clk);
        #1;
        chk("wrap1 out_pc", bus1.out_pc, 32'hFFFF_FFFC);
        chk("wrap1 out_instr", bus1.out_instr, 32'h5A5A_FFFC);
        @(posedge clk);
        #1;
        chk("wrap2 out_pc", bus1.out_pc, 32'h0000_0000);
        chk("wrap2 out_instr", bus1.out_instr, 32'hA5A5_0000);
        chk("wrap2 imem_addr", bus1.imem_addr, 32'h0000_0004);
        chk("wrap2 fetch_count", bus1.fetch_count, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
